// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory path: load/store size codes, MEM-stage
// FSM states, store byte-lane masks and the helpers that derive them.
package riscv_pkg;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } mem_state_e;

  // True when the size code exists for this access kind and the address is
  // naturally aligned; unsigned codes have no store counterpart.
  function automatic logic access_ok(input logic [2:0] f3, input logic is_store,
                                     input logic [1:0] off);
    case (f3)
      F3_BYTE:   return 1'b1;
      F3_HALF:   return !off[0];
      F3_WORD:   return off == 2'b00;
      F3_BYTE_U: return !is_store;
      F3_HALF_U: return !is_store && !off[0];
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_BYTE: return BE_BYTE << off;
      F3_HALF: return off[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_BYTE: return {4{data[7:0]}};
      F3_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load size code.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    byte_sel = rdata[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (func3)
      F3_BYTE:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_HALF:   data = {{16{half_sel[15]}}, half_sel};
      F3_BYTE_U: data = {24'h0, byte_sel};
      F3_HALF_U: data = {16'h0, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls
// the front of the pipe until it completes or times out, and fills MEM/WB.
module memory_access_stage
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        valid_MEM,
  input  logic        memWrite_MEM,
  input  logic        memRead_MEM,
  input  logic        regWrite_MEM,
  input  logic        memToRegWrite_MEM,
  input  logic [2:0]  func3_MEM,
  input  logic [31:0] aluOut_MEM,
  input  logic [31:0] storeData_MEM,
  input  logic [4:0]  rd_MEM,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [3:0]  dmemByteEn,
  output logic [31:0] dmemWData,
  input  logic [31:0] dmemRData,
  input  logic        dmemReady,
  output logic        stall_MEM,
  output logic        valid_WB,
  output logic        regWrite_WB,
  output logic        memToRegWrite_WB,
  output logic [4:0]  rd_WB,
  output logic [31:0] aluOut_WB,
  output logic [31:0] loadData_WB,
  output logic        misaligned,
  output logic        busErr
);

  localparam int               CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;
  logic             we_q, reg_write_q, mem_to_reg_q;
  logic [2:0]       func3_q;
  logic [4:0]       rd_q;
  logic [31:0]      load_data;

  logic is_mem, access_legal, accept, bad_access, timeout;

  assign is_mem       = valid_MEM && (memRead_MEM || memWrite_MEM);
  assign access_legal = access_ok(func3_MEM, memWrite_MEM, aluOut_MEM[1:0]);
  assign accept       = (state_q == S_IDLE) && is_mem && access_legal;
  assign bad_access   = is_mem && !access_legal;
  // The abort happens in the last permitted ACCESS cycle, so the request is
  // held for exactly MAX_WAIT cycles.
  assign timeout      = (state_q == S_ACCESS) && !dmemReady && (wait_q == LAST_WAIT);

  load_align u_load_align (
    .rdata    (dmemRData),
    .byte_off (addr_q[1:0]),
    .func3    (func3_q),
    .data     (load_data)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    dmemReq    = 1'b0;
    dmemWe     = 1'b0;
    dmemAddr   = '0;
    dmemByteEn = '0;
    dmemWData  = '0;
    stall_MEM  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_MEM = accept;
        if (accept) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        dmemReq    = 1'b1;
        dmemWe     = we_q;
        dmemAddr   = {addr_q[31:2], 2'b00};
        dmemByteEn = be_q;
        dmemWData  = wdata_q;
        stall_MEM  = !dmemReady && !timeout;
        if (dmemReady || timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The idle-state stall depends on live inputs; keep it low while in reset.
    if (!rstN) stall_MEM = 1'b0;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wait_q           <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      be_q             <= '0;
      we_q             <= 1'b0;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      func3_q          <= '0;
      rd_q             <= '0;
      valid_WB         <= 1'b0;
      regWrite_WB      <= 1'b0;
      memToRegWrite_WB <= 1'b0;
      rd_WB            <= '0;
      aluOut_WB        <= '0;
      loadData_WB      <= '0;
      misaligned       <= 1'b0;
      busErr           <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      if (state_q == S_IDLE) begin
        if (accept) begin
          wait_q           <= '0;
          addr_q           <= aluOut_MEM;
          we_q             <= memWrite_MEM;
          be_q             <= memWrite_MEM ? store_byte_en(func3_MEM, aluOut_MEM[1:0]) : 4'b0000;
          wdata_q          <= memWrite_MEM ? store_lanes(func3_MEM, storeData_MEM) : 32'h0;
          func3_q          <= func3_MEM;
          rd_q             <= rd_MEM;
          reg_write_q      <= regWrite_MEM;
          mem_to_reg_q     <= memToRegWrite_MEM;
          valid_WB         <= 1'b0;
          regWrite_WB      <= 1'b0;
          memToRegWrite_WB <= 1'b0;
        end else begin
          // Non-memory, bubble or rejected access: straight through to WB.
          valid_WB         <= valid_MEM;
          regWrite_WB      <= valid_MEM && regWrite_MEM && !bad_access;
          memToRegWrite_WB <= valid_MEM && memToRegWrite_MEM && !bad_access;
          rd_WB            <= rd_MEM;
          aluOut_WB        <= aluOut_MEM;
          loadData_WB      <= '0;
          misaligned       <= bad_access;
        end
      end else if (dmemReady || timeout) begin
        valid_WB         <= 1'b1;
        regWrite_WB      <= dmemReady && reg_write_q;
        memToRegWrite_WB <= dmemReady && mem_to_reg_q;
        rd_WB            <= rd_q;
        aluOut_WB        <= addr_q;
        loadData_WB      <= (dmemReady && !we_q) ? load_data : 32'h0;
        if (timeout) busErr <= 1'b1;
      end else begin
        wait_q           <= wait_q + CNT_W'(1);
        valid_WB         <= 1'b0;
        regWrite_WB      <= 1'b0;
        memToRegWrite_WB <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed vector bench for memory_access_stage: a table of load/store/ALU
// cases with hand-computed results plus reset sequences.
module tb_memory_access_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rstN;
  logic        valid_MEM, memWrite_MEM, memRead_MEM, regWrite_MEM, memToRegWrite_MEM;
  logic [2:0]  func3_MEM;
  logic [31:0] aluOut_MEM, storeData_MEM;
  logic [4:0]  rd_MEM;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWData, dmemRData;
  logic [3:0]  dmemByteEn;
  logic        dmemReady, stall_MEM;
  logic        valid_WB, regWrite_WB, memToRegWrite_WB;
  logic [4:0]  rd_WB;
  logic [31:0] aluOut_WB, loadData_WB;
  logic        misaligned, busErr;

  int n_checks = 0;
  int n_fail   = 0;

  memory_access_stage #(.MAX_WAIT(15)) dut (
    .clk               (clk),
    .rstN              (rstN),
    .valid_MEM         (valid_MEM),
    .memWrite_MEM      (memWrite_MEM),
    .memRead_MEM       (memRead_MEM),
    .regWrite_MEM      (regWrite_MEM),
    .memToRegWrite_MEM (memToRegWrite_MEM),
    .func3_MEM         (func3_MEM),
    .aluOut_MEM        (aluOut_MEM),
    .storeData_MEM     (storeData_MEM),
    .rd_MEM            (rd_MEM),
    .dmemReq           (dmemReq),
    .dmemWe            (dmemWe),
    .dmemAddr          (dmemAddr),
    .dmemByteEn        (dmemByteEn),
    .dmemWData         (dmemWData),
    .dmemRData         (dmemRData),
    .dmemReady         (dmemReady),
    .stall_MEM         (stall_MEM),
    .valid_WB          (valid_WB),
    .regWrite_WB       (regWrite_WB),
    .memToRegWrite_WB  (memToRegWrite_WB),
    .rd_WB             (rd_WB),
    .aluOut_WB         (aluOut_WB),
    .loadData_WB       (loadData_WB),
    .misaligned        (misaligned),
    .busErr            (busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        valid, mw, mr, rw, m2r;
    logic [2:0]  f3;
    logic [31:0] alu, sdata;
    logic [4:0]  rd;
    int          ready_after;  // ACCESS cycles before dmemReady; large = never
    logic [31:0] rdata;
    logic        ready_idle;   // drive a stray dmemReady with no request
    int          stalls, reqs;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wb_valid, wb_rw, wb_m2r;
    logic [31:0] load;
    logic        mis, bus_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input string name, input logic valid, mw, mr, rw, m2r, input logic [2:0] f3,
    input logic [31:0] alu, sdata, input logic [4:0] rd, input int ready_after,
    input logic [31:0] rdata, input logic ready_idle, input int stalls, reqs,
    input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
    input logic wb_valid, wb_rw, wb_m2r, input logic [31:0] load, input logic mis, bus_err);
    vec_t v;
    v.name = name; v.valid = valid; v.mw = mw; v.mr = mr; v.rw = rw; v.m2r = m2r;
    v.f3 = f3; v.alu = alu; v.sdata = sdata; v.rd = rd; v.ready_after = ready_after;
    v.rdata = rdata; v.ready_idle = ready_idle; v.stalls = stalls; v.reqs = reqs;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.wb_valid = wb_valid;
    v.wb_rw = wb_rw; v.wb_m2r = wb_m2r; v.load = load; v.mis = mis; v.bus_err = bus_err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_MEM = 1'b0; memWrite_MEM = 1'b0; memRead_MEM = 1'b0; regWrite_MEM = 1'b0;
    memToRegWrite_MEM = 1'b0; func3_MEM = 3'b000; aluOut_MEM = '0; storeData_MEM = '0;
    rd_MEM = '0; dmemReady = 1'b0; dmemRData = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    valid_MEM = v.valid; memWrite_MEM = v.mw; memRead_MEM = v.mr; regWrite_MEM = v.rw;
    memToRegWrite_MEM = v.m2r; func3_MEM = v.f3; aluOut_MEM = v.alu;
    storeData_MEM = v.sdata; rd_MEM = v.rd;
  endtask

  task automatic apply(input vec_t v);
    int          stall_n = 0;
    int          req_n   = 0;
    logic        done    = 1'b0;
    logic        cap_we  = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_be  = '0;
    @(negedge clk);
    drive_vec(v);
    dmemReady = v.ready_idle;
    dmemRData = v.ready_idle ? 32'h5A5A_5A5A : 32'h0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (dmemReq) begin
        if (req_n == 0) begin
          cap_we = dmemWe; cap_addr = dmemAddr; cap_be = dmemByteEn; cap_wdata = dmemWData;
        end
        if (req_n == v.ready_after) begin
          dmemReady = 1'b1;
          dmemRData = v.rdata;
        end
        req_n++;
      end
      #1;
      if (stall_MEM) stall_n++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      dmemReady = 1'b0;
      dmemRData = '0;
    end
    check1({v.name, "/complete"}, done, 1'b1);
    check({v.name, "/stall_cycles"}, stall_n, v.stalls);
    check({v.name, "/req_cycles"}, req_n, v.reqs);
    if (v.reqs > 0) begin
      check1({v.name, "/dmemWe"}, cap_we, v.we);
      check({v.name, "/dmemAddr"}, cap_addr, v.addr);
      check({v.name, "/dmemByteEn"}, {28'h0, cap_be}, {28'h0, v.be});
      check({v.name, "/dmemWData"}, cap_wdata, v.wdata);
    end
    check1({v.name, "/valid_WB"}, valid_WB, v.wb_valid);
    check1({v.name, "/regWrite_WB"}, regWrite_WB, v.wb_rw);
    check1({v.name, "/memToRegWrite_WB"}, memToRegWrite_WB, v.wb_m2r);
    if (v.wb_valid) begin
      check({v.name, "/rd_WB"}, {27'h0, rd_WB}, {27'h0, v.rd});
      check({v.name, "/aluOut_WB"}, aluOut_WB, v.alu);
    end
    check({v.name, "/loadData_WB"}, loadData_WB, v.load);
    check1({v.name, "/misaligned"}, misaligned, v.mis);
    check1({v.name, "/busErr"}, busErr, v.bus_err);
    // One idle cycle: the error pulse must drop and the bubble reaches WB.
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check1({v.name, "/misaligned_drop"}, misaligned, 1'b0);
    check1({v.name, "/idle_valid_WB"}, valid_WB, 1'b0);
  endtask

  initial begin
    //              name          v  mw mr rw m2r f3      alu           sdata         rd  rdy rdata         ri  st  rq we addr          be       wdata         wv rw m2 load          mis be
    tbl.push_back(mk("lw_100",     1, 0, 1, 1, 1, 3'b010, 32'h100,      32'h0,        5,  3,  32'hDEADBEEF, 0,  4,  4, 0, 32'h100,      4'b0000, 32'h0,        1, 1, 1, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk("lb_103",     1, 0, 1, 1, 1, 3'b000, 32'h103,      32'h0,        6,  0,  32'h80FFFF7F, 0,  1,  1, 0, 32'h100,      4'b0000, 32'h0,        1, 1, 1, 32'hFFFFFF80, 0, 0));
    tbl.push_back(mk("lbu_103",    1, 0, 1, 1, 1, 3'b100, 32'h103,      32'h0,        6,  0,  32'h80FFFF7F, 0,  1,  1, 0, 32'h100,      4'b0000, 32'h0,        1, 1, 1, 32'h00000080, 0, 0));
    tbl.push_back(mk("lh_102",     1, 0, 1, 1, 1, 3'b001, 32'h102,      32'h0,        7,  1,  32'h80017FFF, 0,  2,  2, 0, 32'h100,      4'b0000, 32'h0,        1, 1, 1, 32'hFFFF8001, 0, 0));
    tbl.push_back(mk("lhu_100",    1, 0, 1, 1, 1, 3'b101, 32'h100,      32'h0,        7,  0,  32'h1234F00D, 0,  1,  1, 0, 32'h100,      4'b0000, 32'h0,        1, 1, 1, 32'h0000F00D, 0, 0));
    tbl.push_back(mk("sh_206",     1, 1, 0, 0, 0, 3'b001, 32'h206,      32'h1234ABCD, 0,  0,  32'h0,        0,  1,  1, 1, 32'h204,      4'b1100, 32'hABCDABCD, 1, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("sb_301",     1, 1, 0, 0, 0, 3'b000, 32'h301,      32'h000000A5, 0,  2,  32'h0,        0,  3,  3, 1, 32'h300,      4'b0010, 32'hA5A5A5A5, 1, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("sw_40c",     1, 1, 0, 0, 0, 3'b010, 32'h40C,      32'hCAFEF00D, 0,  0,  32'h0,        0,  1,  1, 1, 32'h40C,      4'b1111, 32'hCAFEF00D, 1, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("lw_102_mis", 1, 0, 1, 1, 1, 3'b010, 32'h102,      32'h0,        8,  0,  32'h0,        0,  0,  0, 0, 32'h0,        4'b0000, 32'h0,        1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk("sh_205_mis", 1, 1, 0, 0, 0, 3'b001, 32'h205,      32'h1234ABCD, 0,  0,  32'h0,        0,  0,  0, 0, 32'h0,        4'b0000, 32'h0,        1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk("ld_f3_011",  1, 0, 1, 1, 1, 3'b011, 32'h100,      32'h0,        8,  0,  32'h0,        0,  0,  0, 0, 32'h0,        4'b0000, 32'h0,        1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk("alu_op",     1, 0, 0, 1, 0, 3'b000, 32'h12345678, 32'h0,        9,  0,  32'h0,        1,  0,  0, 0, 32'h0,        4'b0000, 32'h0,        1, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mk("bubble_ld",  0, 0, 1, 1, 1, 3'b010, 32'h100,      32'h0,        10, 0,  32'h0,        0,  0,  0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("lw_timeout", 1, 0, 1, 1, 1, 3'b010, 32'h500,      32'h0,        11, 99, 32'h0,        0,  15, 15, 0, 32'h500,     4'b0000, 32'h0,        1, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk("lw_sticky",  1, 0, 1, 1, 1, 3'b010, 32'h104,      32'h0,        12, 0,  32'h0BADF00D, 0,  1,  1, 0, 32'h104,      4'b0000, 32'h0,        1, 1, 1, 32'h0BADF00D, 0, 1));

    // Reset with a load already presented: nothing may leak out.
    rstN = 1'b0;
    drive_idle();
    valid_MEM = 1'b1; memRead_MEM = 1'b1; func3_MEM = F3_WORD; aluOut_MEM = 32'h100;
    #12;
    check1("reset/dmemReq", dmemReq, 1'b0);
    check1("reset/stall_MEM", stall_MEM, 1'b0);
    check1("reset/valid_WB", valid_WB, 1'b0);
    check1("reset/regWrite_WB", regWrite_WB, 1'b0);
    check("reset/loadData_WB", loadData_WB, 32'h0);
    check1("reset/busErr", busErr, 1'b0);
    check1("reset/misaligned", misaligned, 1'b0);
    @(negedge clk);
    drive_idle();
    rstN = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted mid-ACCESS, between clock edges.
    @(negedge clk);
    drive_vec(mk("lw_600", 1, 0, 1, 1, 1, 3'b010, 32'h600, 32'h0, 3, 0, 32'h0, 0,
                 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 0, 0, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    check1("midrst/dmemReq_before", dmemReq, 1'b1);
    check1("midrst/busErr_before", busErr, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    check1("midrst/dmemReq", dmemReq, 1'b0);
    check1("midrst/stall_MEM", stall_MEM, 1'b0);
    check1("midrst/busErr", busErr, 1'b0);
    check1("midrst/valid_WB", valid_WB, 1'b0);
    check({"midrst/aluOut_WB"}, aluOut_WB, 32'h0);
    @(negedge clk);
    drive_idle();
    rstN = 1'b1;

    apply(mk("lw_recover", 1, 0, 1, 1, 1, 3'b010, 32'h108, 32'h0, 13, 1, 32'h13579BDF, 0,
             2, 2, 0, 32'h108, 4'b0000, 32'h0, 1, 1, 1, 32'h13579BDF, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, max cycles awaiting dmemReady before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_MEM  input  1  EX/MEM register holds a live instruction.
REQ-005 SHALL have port memWrite_MEM  input  1  store.
REQ-006 SHALL have port memRead_MEM  input  1  load.
REQ-007 SHALL have port regWrite_MEM  input  1  instruction writes rd.
REQ-008 SHALL have port memToRegWrite_MEM  input  1  writeback selects load data.
REQ-009 SHALL have port func3_MEM  input  3  access size/sign.
REQ-010 SHALL have port aluOut_MEM  input  32  effective address or ALU result.
REQ-011 SHALL have port storeData_MEM  input  32  rs2 store data.
REQ-012 SHALL have port rd_MEM  input  5  destination register.
REQ-013 SHALL have port dmemReq  output  1  data-memory request.
REQ-014 SHALL have port dmemWe  output  1  request is a write.
REQ-015 SHALL have port dmemAddr  output  32  word address, bits[1:0]=0.
REQ-016 SHALL have port dmemByteEn  output  4  write byte lanes.
REQ-017 SHALL have port dmemWData  output  32  lane-replicated write data.
REQ-018 SHALL have port dmemRData  input  32  read word, valid with dmemReady.
REQ-019 SHALL have port dmemReady  input  1  request completes this cycle.
REQ-020 SHALL have port stall_MEM  output  1  hold IF..EX/MEM this cycle.
REQ-021 SHALL have ports valid_WB, regWrite_WB, memToRegWrite_WB  output  1 each  registered MEM/WB controls.
REQ-022 SHALL have ports rd_WB  output  5; aluOut_WB, loadData_WB  output  32 each  registered MEM/WB data.
REQ-023 SHALL have port misaligned  output  1  one-cycle pulse: misaligned/illegal access.
REQ-024 SHALL have port busErr  output  1  sticky timeout flag.

Function
REQ-025 SHALL have FSM IDLE/ACCESS; IDLE + valid_MEM + (memRead|memWrite) + aligned -> ACCESS, latching address, we, byteEn, wdata, func3, rd, controls; stall_MEM=1 that cycle.
REQ-026 SHALL, in ACCESS, drive dmemReq=1 from latched values; stall_MEM=!dmemReady; on dmemReady load MEM/WB (valid_WB=1, loadData_WB=aligned dmemRData) and return to IDLE; minimum load/store latency 2 cycles.
REQ-027 SHALL pass non-memory instructions to MEM/WB in one cycle, no stall; valid_MEM=0 loads valid_WB=0.
REQ-028 SHALL decode func3 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; others illegal.
REQ-029 SHALL byte-enable SB 1<<addr[1:0], SH 0011/1100 by addr[1], SW 1111; wdata byte/half replicated across lanes.
REQ-030 SHALL extract loads by addr[1:0], sign-extend LB/LH, zero-extend LBU/LHU.
REQ-031 SHALL, on halfword addr[0]=1, word addr[1:0]!=0, or illegal func3: issue no request, pulse misaligned, pass to WB in one cycle with regWrite_WB=0.
REQ-032 SHALL count ACCESS cycles; at MAX_WAIT without dmemReady: drop dmemReq, set busErr, write WB with regWrite_WB=0, return to IDLE.
REQ-033 SHALL ignore dmemReady outside ACCESS.

Reset
REQ-034 SHALL, on rstN=0 (any time, including mid-ACCESS), immediately force IDLE, counter 0, all outputs 0 (dmemReq, stall_MEM, busErr, all *_WB).
REQ-035 SHALL only clear busErr by reset.

Structure
REQ-036 SHALL place func3 codes, FSM state enum and byte-enable constants in shared package riscv_pkg.
REQ-037 SHALL implement load extraction as combinational sub-module load_align.

Verification
REQ-038 SHALL test LW addr 0x100, dmemReady after 3 ACCESS cycles, rdata 0xDEADBEEF -> stall_MEM high 4 cycles, loadData_WB=0xDEADBEEF, regWrite_WB=1.
REQ-039 SHALL test LB addr 0x103, rdata 0x80FF_FF7F -> loadData_WB=0xFFFFFF80; LBU same -> 0x00000080.
REQ-040 SHALL test SH addr 0x206, data 0x1234ABCD -> dmemByteEn=1100, dmemWData=0xABCDABCD, dmemWe=1.
REQ-041 SHALL test LW addr 0x102 -> misaligned pulse, dmemReq never 1, regWrite_WB=0, no stall.
REQ-042 SHALL test dmemReady held 0 -> abort after 15 cycles, busErr=1; then rstN low mid-ACCESS -> dmemReq=0 same cycle, busErr=0.
